parent_link_root_endpoint: RTL and testbench
============================================

Name: parent_link_root_endpoint

Overview:
- Root-side termination of the 64-bit parent link; it connects to a child FPGA's parent_rx/parent_tx ports.
- Downstream path: packs pairs of 32-bit host words into 64-bit messages for the child.
- Upstream path: splits 64-bit child messages into two 32-bit host words.
- Tracks outstanding requests that expect a response and flags responses that never arrive.

Parameters:
- NUM_FPGAS, 5, number of FPGAs on the link; valid source IDs are 0..NUM_FPGAS-1.
- MAX_OUTSTANDING, 4, maximum unanswered response-expected messages (1..255).
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles (used only with the optional feature).
- OUT_W, 8, width of the outstanding counter.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- host_in_data  in  32  host word stream.
- host_in_valid  in  1  host word valid.
- host_in_ready  out  1  host word accepted when valid&ready.
- host_out_data  out  32  word stream to host.
- host_out_valid  out  1  output word valid.
- host_out_ready  in  1  host accepts output word.
- child_tx_data  out  64  message to child parent_rx.
- child_tx_valid  out  1  message valid.
- child_tx_ready  in  1  child accepts message.
- child_rx_data  in  64  message from child parent_tx.
- child_rx_valid  in  1  message valid.
- child_rx_ready  out  1  endpoint accepts message.
- outstanding  out  OUT_W  current unanswered request count.
- link_busy  out  1  either path non-idle or outstanding!=0.
- drop_count  out  16  saturating count of dropped upstream messages.
- timeout_error  out  1  sticky watchdog error.

Behaviour:
- Message format: [63:56] FPGA id (dest downstream, src upstream); [55] flag; [54:48] opcode; [47:0] payload.
  - Downstream flag = response expected.
  - Upstream flag = is response.
- Reset state: all outputs 0; both FSMs idle; counters 0.
- Downstream FSM:
  - D_HI: host_in_ready=1; on handshake latch word into [63:32] -> D_LO.
  - D_LO: host_in_ready=1; on handshake latch word into [31:0] -> D_SEND.
  - D_SEND: host_in_ready=0. child_tx_valid=1 unless (flag && outstanding==MAX_OUTSTANDING); the stall holds data stable.
  - D_SEND, on tx handshake: -> D_HI; outstanding+1 if flag set.
  - child_tx_valid, once asserted, stays high with data stable until child_tx_ready.
  - Latency: child_tx_valid rises the cycle after the second word handshake. Minimum 3 cycles per message.
- Upstream FSM:
  - U_IDLE: child_rx_ready=1; on handshake capture message.
  - Drop if src id >= NUM_FPGAS, or if flag set while outstanding==0 (spurious response). A dropped message increments drop_count (saturating at 0xFFFF) and the FSM stays in U_IDLE.
  - Otherwise: if flag set, outstanding-1; then -> U_HI.
  - U_HI: host_out_data=[63:32], valid=1; on ready -> U_LO.
  - U_LO: host_out_data=[31:0], valid=1; on ready -> U_IDLE.
  - child_rx_ready=0 outside U_IDLE.
  - host_out_valid never drops without a handshake.
- Simultaneous increment (tx) and decrement (rx) in one cycle: outstanding unchanged.
- outstanding never exceeds MAX_OUTSTANDING and never underflows.
- link_busy is registered from the next-state values (same cycle as the FSMs).
- Reset asserted mid-message: partial words and in-flight messages are discarded; outputs return to 0 on the next edge.

Optional Feature:
- Macro: PARENT_LINK_TIMEOUT_EN.
- With the macro defined:
  - Watchdog counter cleared when outstanding==0 or on any accepted response.
  - Otherwise increments each cycle while outstanding>0.
  - On reaching TIMEOUT_CYCLES, sets timeout_error (sticky until reset) and holds the counter.
  - outstanding is not modified by a timeout.
- Without the macro: no counter logic; timeout_error tied 0.

Test Plan:
1. Host sends 0xAA01_0000 then 0x1234_5678, child_tx_ready=1 -> child_tx_data=0xAA01_0000_1234_5678, child_tx_valid for exactly 1 cycle, outstanding stays 0.
2. Four messages with [55]=1, MAX_OUTSTANDING=4, then a fifth -> outstanding=4; fifth held with child_tx_valid=0; one rx response (src 2, flag 1) -> outstanding 3, fifth sent, outstanding back to 4.
3. child_rx_data=0x0280_0000_DEAD_BEEF with host_out_ready toggling 1/0 -> host sees 0x0280_0000 then 0xDEADBEEF, each held until accepted; outstanding decrements once.
4. rx message with src id 7 (NUM_FPGAS=5), then a response with outstanding=0 -> no host output, drop_count=2.
5. Same-cycle tx handshake with flag and rx response accepted at outstanding=2 -> outstanding stays 2; reset=0 mid D_LO -> all outputs 0 next cycle, first post-reset word treated as high half.
6. With PARENT_LINK_TIMEOUT_EN, TIMEOUT_CYCLES=100, one request, no response -> timeout_error=1 after 100 cycles, remains 1 after a later response, clears only on reset.

Source files
------------

// File: rtl/parent_link_root_endpoint.sv
// -----------------------------------------------------------------------------
// parent_link_root_endpoint
//
// Root-side termination of the 64-bit parent link. Connects to a child FPGA's
// parent_rx / parent_tx ports.
//
//   Downstream: two 32-bit host words (high half first) are packed into one
//               64-bit message and offered to the child.
//   Upstream:   each accepted 64-bit child message is returned to the host as
//               two 32-bit words (high half first).
//   Tracking:   downstream messages with the flag bit set expect a response;
//               upstream messages with the flag bit set are responses. The
//               difference is kept in 'outstanding' and bounded by
//               MAX_OUTSTANDING.
//
// Message format: [63:56] FPGA id, [55] flag, [54:48] opcode, [47:0] payload.
//
// Ports
//   clk                 single clock, rising edge
//   reset               synchronous, active-low
//   host_in_*           32-bit host word stream in (valid/ready)
//   host_out_*          32-bit word stream to the host (valid/ready)
//   child_tx_*          64-bit messages to the child (valid/ready)
//   child_rx_*          64-bit messages from the child (valid/ready)
//   outstanding         unanswered response-expected messages
//   link_busy           either path non-idle or outstanding != 0
//   drop_count          saturating count of dropped upstream messages
//   timeout_error       sticky watchdog error
//
// Optional feature: define PARENT_LINK_TIMEOUT_EN to build the response
// watchdog. Without it timeout_error is tied low.
//
// All outputs are registered from next-state values, so every output is 0 in
// the cycle after a reset edge and handshakes always see registered signals.
// -----------------------------------------------------------------------------
module parent_link_root_endpoint #(
  parameter int NUM_FPGAS       = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int OUT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [31:0]      host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic [63:0]      child_tx_data,
  output logic             child_tx_valid,
  input  logic             child_tx_ready,
  input  logic [63:0]      child_rx_data,
  input  logic             child_rx_valid,
  output logic             child_rx_ready,
  output logic [OUT_W-1:0] outstanding,
  output logic             link_busy,
  output logic [15:0]      drop_count,
  output logic             timeout_error
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255 ||
      MAX_OUTSTANDING > (1 << OUT_W) - 1) begin : g_bad_max_outstanding
    $error("MAX_OUTSTANDING must be 1..255 and fit in OUT_W bits");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [OUT_W-1:0] MAX_OUT    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [8:0]       NUM_FPGA_W = 9'(NUM_FPGAS);

  typedef enum logic [1:0] {D_HI, D_LO, D_SEND} d_state_t;
  typedef enum logic [1:0] {U_IDLE, U_HI, U_LO} u_state_t;

  d_state_t         d_state, d_next;
  u_state_t         u_state, u_next;
  logic [63:0]      tx_msg_next;
  logic [63:0]      rx_msg, rx_msg_next;
  logic [OUT_W-1:0] out_next;
  logic [15:0]      drop_next;

  // Handshakes are formed from the registered output strobes.
  logic host_in_fire, host_out_fire, tx_fire, rx_fire;
  assign host_in_fire  = host_in_valid  & host_in_ready;
  assign host_out_fire = host_out_valid & host_out_ready;
  assign tx_fire       = child_tx_valid & child_tx_ready;
  assign rx_fire       = child_rx_valid & child_rx_ready;

  logic rx_bad_src, rx_spurious, rx_drop, rsp_accept, tx_inc;

  // Next values of the registered outputs.
  logic        host_in_ready_d, child_tx_valid_d, child_rx_ready_d;
  logic        host_out_valid_d, link_busy_d;
  logic [31:0] host_out_data_d;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_state        <= D_HI;
      u_state        <= U_IDLE;
      rx_msg         <= '0;
      child_tx_data  <= '0;
      outstanding    <= '0;
      drop_count     <= '0;
      host_in_ready  <= 1'b0;
      child_tx_valid <= 1'b0;
      child_rx_ready <= 1'b0;
      host_out_valid <= 1'b0;
      host_out_data  <= '0;
      link_busy      <= 1'b0;
    end else begin
      d_state        <= d_next;
      u_state        <= u_next;
      rx_msg         <= rx_msg_next;
      child_tx_data  <= tx_msg_next;
      outstanding    <= out_next;
      drop_count     <= drop_next;
      host_in_ready  <= host_in_ready_d;
      child_tx_valid <= child_tx_valid_d;
      child_rx_ready <= child_rx_ready_d;
      host_out_valid <= host_out_valid_d;
      host_out_data  <= host_out_data_d;
      link_busy      <= link_busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    d_next      = d_state;
    tx_msg_next = child_tx_data;
    u_next      = u_state;
    rx_msg_next = rx_msg;
    rx_drop     = 1'b0;
    rsp_accept  = 1'b0;

    // Downstream packer
    case (d_state)
      D_HI: if (host_in_fire) begin
        tx_msg_next[63:32] = host_in_data;
        d_next             = D_LO;
      end
      D_LO: if (host_in_fire) begin
        tx_msg_next[31:0] = host_in_data;
        d_next            = D_SEND;
      end
      D_SEND: if (tx_fire) d_next = D_HI;
      default: d_next = D_HI;
    endcase

    // Upstream splitter. A spurious response is judged against the count
    // before this edge, so a same-cycle downstream increment does not rescue it.
    rx_bad_src  = {1'b0, child_rx_data[63:56]} >= NUM_FPGA_W;
    rx_spurious = child_rx_data[55] && (outstanding == '0);
    case (u_state)
      U_IDLE: if (rx_fire) begin
        if (rx_bad_src || rx_spurious) begin
          rx_drop = 1'b1;
        end else begin
          rx_msg_next = child_rx_data;
          rsp_accept  = child_rx_data[55];
          u_next      = U_HI;
        end
      end
      U_HI: if (host_out_fire) u_next = U_LO;
      U_LO: if (host_out_fire) u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase

    // Outstanding tracking; simultaneous increment and decrement cancel.
    tx_inc = tx_fire && child_tx_data[55];
    case ({tx_inc, rsp_accept})
      2'b10:   out_next = (outstanding < MAX_OUT) ? outstanding + 1'b1 : outstanding;
      2'b01:   out_next = (outstanding != '0) ? outstanding - 1'b1 : outstanding;
      default: out_next = outstanding;
    endcase

    drop_next = (rx_drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
  end

  // ---------------------------------------------------------------------------
  // Output decode from next-state values
  // ---------------------------------------------------------------------------
  always_comb begin
    host_in_ready_d  = (d_next == D_HI) || (d_next == D_LO);
    // A flagged message waits while the window is full. Once raised, valid
    // cannot fall without a handshake: only a transmit can grow the count.
    child_tx_valid_d = (d_next == D_SEND) && !(tx_msg_next[55] && out_next == MAX_OUT);
    child_rx_ready_d = (u_next == U_IDLE);
    host_out_valid_d = (u_next != U_IDLE);
    case (u_next)
      U_HI:    host_out_data_d = rx_msg_next[63:32];
      U_LO:    host_out_data_d = rx_msg_next[31:0];
      default: host_out_data_d = '0;
    endcase
    link_busy_d = (d_next != D_HI) || (u_next != U_IDLE) || (out_next != '0);
  end

  // ---------------------------------------------------------------------------
  // Optional response watchdog
  // ---------------------------------------------------------------------------
`ifdef PARENT_LINK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // The counter restarts whenever a response arrives, stops at the limit and
  // the error stays set until reset; outstanding itself is left untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt        <= '0;
      timeout_error <= 1'b0;
    end else if (outstanding == '0 || rsp_accept) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) timeout_error <= 1'b1;
    end
  end
`else
  assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_parent_link_root_endpoint.sv
// -----------------------------------------------------------------------------
// Bench for parent_link_root_endpoint: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model that
// tracks buffered host words, queued upstream words and the response window.
// -----------------------------------------------------------------------------
module tb_parent_link_root_endpoint;

  localparam int NUM_FPGAS = 5;
  localparam int MAX_OUT   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [31:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [63:0] child_tx_data;
  logic        child_tx_valid;
  logic        child_tx_ready;
  logic [63:0] child_rx_data;
  logic        child_rx_valid;
  logic        child_rx_ready;
  logic [7:0]  outstanding;
  logic        link_busy;
  logic [15:0] drop_count;
  logic        timeout_error;

  parent_link_root_endpoint #(
    .NUM_FPGAS      (NUM_FPGAS),
    .MAX_OUTSTANDING(MAX_OUT),
    .TIMEOUT_CYCLES (65535),
    .OUT_W          (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_in_data  (host_in_data),
    .host_in_valid (host_in_valid),
    .host_in_ready (host_in_ready),
    .host_out_data (host_out_data),
    .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready),
    .child_tx_data (child_tx_data),
    .child_tx_valid(child_tx_valid),
    .child_tx_ready(child_tx_ready),
    .child_rx_data (child_rx_data),
    .child_rx_valid(child_rx_valid),
    .child_rx_ready(child_rx_ready),
    .outstanding   (outstanding),
    .link_busy     (link_busy),
    .drop_count    (drop_count),
    .timeout_error (timeout_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (state as seen after the most recent clock edge)
  // ---------------------------------------------------------------------------
  bit          live;      // 0 while reset held and for the edge that releases it
  int          pend;      // host words buffered for the next downstream message
  logic [31:0] hi_w, lo_w;
  int          out_cnt;
  int          drops;
  logic [31:0] us_q[$];   // words still owed to the host

  function automatic bit exp_tx_valid();
    return live && pend == 2 && !(hi_w[23] && out_cnt == MAX_OUT);
  endfunction

  task automatic model_edge(input logic rst_v, input logic hv, input logic [31:0] hd,
                            input logic txr, input logic rxv, input logic [63:0] rxd,
                            input logic hor);
    bit tx_fire, in_fire, rx_fire, ho_fire, flag_tx;
    int rsp;
    if (!rst_v) begin
      live = 0; pend = 0; out_cnt = 0; drops = 0; us_q.delete();
    end else if (!live) begin
      live = 1;
    end else begin
      flag_tx = hi_w[23];
      tx_fire = exp_tx_valid() && txr;
      in_fire = hv && pend < 2;
      rx_fire = rxv && us_q.size() == 0;
      ho_fire = hor && us_q.size() != 0;
      rsp = 0;
      if (ho_fire) void'(us_q.pop_front());
      if (rx_fire) begin
        if (rxd[63:56] >= NUM_FPGAS || (rxd[55] && out_cnt == 0)) begin
          if (drops < 65535) drops++;
        end else begin
          us_q.push_back(rxd[63:32]);
          us_q.push_back(rxd[31:0]);
          rsp = rxd[55] ? 1 : 0;
        end
      end
      out_cnt = out_cnt + ((tx_fire && flag_tx) ? 1 : 0) - rsp;
      if (tx_fire) pend = 0;
      if (in_fire) begin
        if (pend == 0) hi_w = hd; else lo_w = hd;
        pend++;
      end
    end
  endtask

  task automatic check_outputs();
    bit empty = (us_q.size() == 0);
    bit txv   = exp_tx_valid();
    check("host_in_ready", host_in_ready, live && pend < 2);
    check("child_tx_valid", child_tx_valid, txv);
    if (txv || !live) check("child_tx_data", child_tx_data, live ? {hi_w, lo_w} : 64'd0);
    check("child_rx_ready", child_rx_ready, live && empty);
    check("host_out_valid", host_out_valid, !empty);
    if (!empty || !live) check("host_out_data", host_out_data, empty ? 32'd0 : us_q[0]);
    check("outstanding", outstanding, out_cnt);
    check("drop_count", drop_count, drops);
    check("link_busy", link_busy, pend != 0 || !empty || out_cnt != 0);
`ifndef PARENT_LINK_TIMEOUT_EN
    check("timeout_error", timeout_error, 0);
`endif
  endtask

  // Entered at a falling edge: drive, advance one clock, check at the next
  // falling edge.
  task automatic tick(input logic rst_v, input logic hv, input logic [31:0] hd,
                      input logic txr, input logic rxv, input logic [63:0] rxd,
                      input logic hor);
    reset          = rst_v;
    host_in_valid  = hv;
    host_in_data   = hd;
    child_tx_ready = txr;
    child_rx_valid = rxv;
    child_rx_data  = rxd;
    host_out_ready = hor;
    model_edge(rst_v, hv, hd, txr, rxv, rxd, hor);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) tick(1, 0, 32'd0, txr, 0, 64'd0, 1);
  endtask

  // Two host words followed by one tick in which the packer may transmit.
  task automatic send_msg(input logic [31:0] hi, input logic [31:0] lo, input logic txr);
    tick(1, 1, hi, txr, 0, 64'd0, 1);
    tick(1, 1, lo, txr, 0, 64'd0, 1);
    tick(1, 0, 32'd0, txr, 0, 64'd0, 1);
  endtask

  function automatic logic [31:0] rand_hi();
    logic [7:0] id = 8'($urandom_range(0, 7));
    logic       fl = 1'($urandom_range(0, 1));
    return {id, fl, 23'($urandom)};
  endfunction

  initial begin
    reset = 1'b0; host_in_valid = 1'b0; host_in_data = '0; child_tx_ready = 1'b0;
    child_rx_valid = 1'b0; child_rx_data = '0; host_out_ready = 1'b0;
    live = 0; pend = 0; out_cnt = 0; drops = 0; hi_w = '0; lo_w = '0;
    @(negedge clk);

    // Reset with busy inputs: everything must stay at 0.
    for (int i = 0; i < 3; i++) tick(0, 1, $urandom, 1, 1, {$urandom, $urandom}, 1);
    tick(1, 0, 32'd0, 1, 0, 64'd0, 1);

    // Basic pack: two words become one message, valid for a single cycle.
    tick(1, 1, 32'hAA01_0000, 1, 0, 64'd0, 1);
    tick(1, 1, 32'h1234_5678, 1, 0, 64'd0, 1);
    check("t1_data", child_tx_data, 64'hAA01_0000_1234_5678);
    check("t1_valid", child_tx_valid, 1);
    idle(1, 1);
    check("t1_valid_once", child_tx_valid, 0);
    check("t1_out0", outstanding, 0);
    idle(1, 1);

    // Drops: unknown source, then a response with nothing outstanding.
    tick(1, 0, 32'd0, 1, 1, 64'h0700_0000_1111_2222, 1);
    tick(1, 0, 32'd0, 1, 1, 64'h0180_0000_3333_4444, 1);
    idle(2, 1);
    check("t4_drops", drop_count, 2);
    check("t4_no_host", host_out_valid, 0);

    // Fill the response window, fifth request must wait.
    for (int k = 0; k < 5; k++) send_msg(32'h0180_0000 | k, 32'(k), 1);
    idle(3, 1);
    check("t2_out4", outstanding, 4);
    check("t2_stall", child_tx_valid, 0);
    tick(1, 0, 32'd0, 1, 1, 64'h0280_0000_0000_0001, 1);
    check("t2_out3", outstanding, 3);
    idle(4, 1);
    check("t2_out_back4", outstanding, 4);

    // Upstream split with a host that only accepts every other cycle.
    tick(1, 0, 32'd0, 1, 1, 64'h0280_0000_DEAD_BEEF, 0);
    check("t3_hi", host_out_data, 32'h0280_0000);
    for (int i = 0; i < 6; i++) tick(1, 0, 32'd0, 1, 0, 64'd0, 1'(i % 2));
    check("t3_out3", outstanding, 3);

    // Same-cycle request transmit and response at outstanding 2.
    tick(1, 0, 32'd0, 1, 1, 64'h0280_0000_0000_0002, 1);
    idle(3, 1);
    tick(1, 1, 32'h0180_0000, 0, 0, 64'd0, 1);
    tick(1, 1, 32'h0000_0055, 0, 0, 64'd0, 1);
    check("t5_pre_out2", outstanding, 2);
    tick(1, 0, 32'd0, 1, 1, 64'h0280_0000_0000_0003, 1);
    check("t5_out2", outstanding, 2);
    idle(3, 1);

    // Reset in the middle of a message; the next word is a high half again.
    tick(1, 1, 32'h0100_0000, 1, 0, 64'd0, 1);
    tick(0, 0, 32'd0, 1, 0, 64'd0, 1);
    check("t5_rst_ready", host_in_ready, 0);
    tick(1, 0, 32'd0, 1, 0, 64'd0, 1);
    tick(1, 1, 32'h0300_1111, 0, 0, 64'd0, 1);
    tick(1, 1, 32'h2222_3333, 0, 0, 64'd0, 1);
    check("t5_post_rst", child_tx_data, 64'h0300_1111_2222_3333);
    idle(2, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [63:0] rxd = {rand_hi(), 32'($urandom)};
      logic        hv  = ($urandom_range(0, 9) < 7);
      logic [31:0] hd  = ($urandom_range(0, 1) != 0) ? rand_hi() : 32'($urandom);
      tick(($urandom_range(0, 499) != 0), hv, hd,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5), rxd,
           ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
